// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Used by serial_subtractor (optional signed-overflow output via SERIAL_SUB_OVF_EN).
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when a<b outright, or when a==b and a borrow is already pending.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB-first at one bit per clock.
// Define SERIAL_SUB_OVF_EN to enable the signed-overflow output ovf (otherwise tied to 0).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bo;

  full_sub_cell u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the work registers are reset too, so an aborted operation leaves no stale partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sd   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sd  <= {w_d, r_sd[WIDTH-1:1]};
      r_br  <= w_bo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= {w_d, r_sd[WIDTH-1:1]};
        r_bout <= w_bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Borrow into the MSB; with the final borrow-out held in r_bout, their XOR is signed overflow.
  logic r_br_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_msb <= 1'b0;
    end else if (w_last) begin
      r_br_msb <= r_br;
    end
  end

  assign ovf = r_br_msb ^ r_bout;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_diff = '0;
  logic         prev_bout = 1'b0;
  logic         prev_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int u;
    int s;
    u  = int'(x) - int'(y) - int'(bi);
    s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
    d  = u[W-1:0];
    bo = (u < 0);
`ifdef SERIAL_SUB_OVF_EN
    ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
`else
    ov = 1'b0;
`endif
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input int glitch);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           n;
    int           busy_cycles;
    int           extra;
    model(x, y, bi, ed, eb, eo);
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; bin = ~bi;
    n = 1;
    busy_cycles = 0;
    while (!done && n < 3 * W) begin
      if (busy) busy_cycles++;
      if (n == W) begin
        check("hold_diff", 32'(diff), 32'(prev_diff));
        check("hold_bout", 32'(bout), 32'(prev_bout));
        check("hold_ovf",  32'(ovf),  32'(prev_ovf));
      end
      start = (n == glitch);
      if (n == glitch) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency",     32'(n), 32'(W + 1));
    check("busy_cycles", 32'(busy_cycles), 32'(W));
    check("busy_done",   32'(busy), 32'(0));
    check("diff",        32'(diff), 32'(ed));
    check("bout",        32'(bout), 32'(eb));
    check("ovf",         32'(ovf),  32'(eo));
    @(negedge clk);
    check("done_pulse",  32'(done), 32'(0));
    check("diff_after",  32'(diff), 32'(ed));
    if (glitch > 0) begin
      extra = 0;
      repeat (2 * W) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("no_queued_done", 32'(extra), 32'(0));
    end
    prev_diff = ed;
    prev_bout = eb;
    prev_ovf  = eo;
  endtask

  initial begin
    int extra;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_bout", 32'(bout), 32'(0));
    check("rst_ovf",  32'(ovf),  32'(0));
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h03, 8'h05, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'hA7, 8'h3C, 1'b0, 3);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 0);
    run_op(8'h10, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h00, 8'hFF, 1'b0, 0);

    // Abort an operation in its fourth cycle; no result may ever appear.
    @(negedge clk);
    a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_diff", 32'(diff), 32'(0));
    check("abort_bout", 32'(bout), 32'(0));
    check("abort_ovf",  32'(ovf),  32'(0));
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'(0));
    prev_diff = '0;
    prev_bout = 1'b0;
    prev_ovf  = 1'b0;

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
